// File: rtl/drfm_cmd_decoder.sv
// ----------------------------------------------------------------------------
// drfm_cmd_decoder
//
// Takes the 32-bit command word from the virtual-JTAG receiver (tck domain)
// into the CLK domain, decodes the per-byte command flags, holds the DRFM
// parameter registers and offers each new parameter set to the DSP chain.
//
// Command word: byte k = {flag, value[6:0]}; k=0 delay, 1 doppler, 2 scale,
// 3 gain.
//
// Ports
//   CLK          in   system clock, sole clock of the block
//   aclr         in   synchronous active-high reset
//   cmd_word     in   command word, stable from an upd_tgl flip until the next
//   upd_tgl      in   toggles once per update-DR (asynchronous to CLK)
//   delay_val    out  delay parameter
//   doppler_val  out  doppler parameter
//   scale_val    out  scale parameter
//   gain_val     out  gain parameter
//   mode         out  0001 delay, 1000 doppler, 0010 scale, 0100 gain, 0000 nop
//   param_valid  out  new parameter set available
//   param_ready  in   consumer accepts (transfer on valid & ready at CLK edge)
//   status       out  {timeout, overrun, multi_cmd, nop}; sticky until aclr
//   readback     out  only with DRFM_CMD_READBACK_EN defined:
//                     {cmd_cnt, status, 1'b0, mode, delay_val, 1'b0, doppler_val}
//
// Handshake: param_valid is high exactly while the FSM is in HANDSHAKE. A
// transfer happens on any CLK edge where param_valid & param_ready are both
// high; param_valid then drops on the next cycle. If param_ready never comes,
// param_valid is withdrawn after TIMEOUT cycles. Values and mode are stable
// while param_valid is high.
//
// Optional feature macro: DRFM_CMD_READBACK_EN
// ----------------------------------------------------------------------------
module drfm_cmd_decoder #(
  parameter int SYNC_STAGES = 2,
  parameter int VAL_W       = 7,
  parameter int TIMEOUT     = 255
) (
  input  logic             CLK,
  input  logic             aclr,
  input  logic [31:0]      cmd_word,
  input  logic             upd_tgl,
  output logic [VAL_W-1:0] delay_val,
  output logic [VAL_W-1:0] doppler_val,
  output logic [VAL_W-1:0] scale_val,
  output logic [VAL_W-1:0] gain_val,
  output logic [3:0]       mode,
  output logic             param_valid,
  input  logic             param_ready,
`ifdef DRFM_CMD_READBACK_EN
  output logic [31:0]      readback,
`endif
  output logic [3:0]       status
);

  localparam int MASK_W = $clog2(SYNC_STAGES + 2);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CAPTURE,
    ST_DECODE,
    ST_HANDSHAKE
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic [MASK_W-1:0]      mask_cnt_q;
  logic                   evt;
  logic                   pend_q;
  logic [31:0]            shadow_q;
  logic [15:0]            to_cnt_q;
  logic                   to_expire;
  logic [3:0]             flags;

  // --------------------------------------------------------------------------
  // Toggle synchronizer. The mask keeps the first propagation of a static
  // upd_tgl level through the reset-cleared chain from looking like an event.
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (aclr) begin
      sync_q     <= '0;
      hist_q     <= 1'b0;
      mask_cnt_q <= MASK_W'(SYNC_STAGES + 1);
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], upd_tgl};
      hist_q <= sync_q[SYNC_STAGES-1];
      if (mask_cnt_q != '0) mask_cnt_q <= mask_cnt_q - 1'b1;
    end
  end

  assign evt = (sync_q[SYNC_STAGES-1] ^ hist_q) && (mask_cnt_q == '0);

  // Flags of the captured word, MSB of each byte; index k = byte k.
  assign flags     = {shadow_q[31], shadow_q[23], shadow_q[15], shadow_q[7]};
  assign to_expire = (to_cnt_q == 16'(TIMEOUT - 1));

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (aclr) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (evt || pend_q) state_d = ST_CAPTURE;
      ST_CAPTURE:   state_d = ST_DECODE;
      ST_DECODE:    state_d = (flags == 4'b0000) ? ST_IDLE : ST_HANDSHAKE;
      ST_HANDSHAKE: if (param_ready || to_expire) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  assign param_valid = (state_q == ST_HANDSHAKE);

  // --------------------------------------------------------------------------
  // Datapath: pending queue, shadow word, parameter registers, status
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (aclr) begin
      pend_q      <= 1'b0;
      shadow_q    <= '0;
      to_cnt_q    <= '0;
      delay_val   <= '0;
      doppler_val <= '0;
      scale_val   <= '0;
      gain_val    <= '0;
      mode        <= 4'b0000;
      status      <= 4'b0000;
    end else begin
      // One-deep event queue. In IDLE a held pend is consumed; an event
      // arriving in that same cycle becomes the new pend.
      if (state_q == ST_IDLE) begin
        pend_q <= pend_q & evt;
      end else if (evt) begin
        if (pend_q) status[2] <= 1'b1;
        else        pend_q    <= 1'b1;
      end

      if (state_q == ST_CAPTURE) shadow_q <= cmd_word;

      if (state_q == ST_DECODE) begin
        if (flags[0]) delay_val   <= shadow_q[VAL_W-1:0];
        if (flags[1]) doppler_val <= shadow_q[8+:VAL_W];
        if (flags[2]) scale_val   <= shadow_q[16+:VAL_W];
        if (flags[3]) gain_val    <= shadow_q[24+:VAL_W];

        if      (flags[0]) mode <= 4'b0001;
        else if (flags[1]) mode <= 4'b1000;
        else if (flags[2]) mode <= 4'b0010;
        else if (flags[3]) mode <= 4'b0100;
        else               mode <= 4'b0000;

        if ((flags[0] & flags[1]) | (flags[0] & flags[2]) | (flags[0] & flags[3]) |
            (flags[1] & flags[2]) | (flags[1] & flags[3]) | (flags[2] & flags[3]))
          status[1] <= 1'b1;
        if (flags == 4'b0000) status[0] <= 1'b1;
      end

      // Timeout counter counts HANDSHAKE cycles from entry.
      if (state_q == ST_HANDSHAKE && !param_ready) begin
        if (to_expire) begin
          status[3] <= 1'b1;
          to_cnt_q  <= '0;
        end else begin
          to_cnt_q  <= to_cnt_q + 16'd1;
        end
      end else begin
        to_cnt_q <= '0;
      end
    end
  end

`ifdef DRFM_CMD_READBACK_EN
  logic [7:0] cmd_cnt_q;

  // Counts every DECODE entry, nop commands included; wraps naturally.
  always_ff @(posedge CLK) begin
    if (aclr)                       cmd_cnt_q <= 8'd0;
    else if (state_q == ST_DECODE)  cmd_cnt_q <= cmd_cnt_q + 8'd1;
  end

  assign readback = {cmd_cnt_q, status, 1'b0, mode, delay_val, 1'b0, doppler_val};
`endif

endmodule

// File: tb/tb_drfm_cmd_decoder.sv
// ----------------------------------------------------------------------------
// tb_drfm_cmd_decoder
//
// Directed bench for drfm_cmd_decoder built with SYNC_STAGES=2, TIMEOUT=8.
// Inputs change and outputs are sampled 1 ns after each rising CLK edge.
// With two sync stages a toggle driven in cycle T gives param_valid in T+5.
// ----------------------------------------------------------------------------
module tb_drfm_cmd_decoder;

  localparam int VAL_W = 7;

  logic             clk;
  logic             aclr;
  logic [31:0]      cmd_word;
  logic             upd_tgl;
  logic [VAL_W-1:0] delay_val, doppler_val, scale_val, gain_val;
  logic [3:0]       mode;
  logic             param_valid;
  logic             param_ready;
  logic [3:0]       status;
`ifdef DRFM_CMD_READBACK_EN
  logic [31:0]      readback;
`endif

  int vectors;
  int miscompares;
  int hi_cnt;

  drfm_cmd_decoder #(
    .SYNC_STAGES (2),
    .VAL_W       (VAL_W),
    .TIMEOUT     (8)
  ) dut (
    .CLK         (clk),
    .aclr        (aclr),
    .cmd_word    (cmd_word),
    .upd_tgl     (upd_tgl),
    .delay_val   (delay_val),
    .doppler_val (doppler_val),
    .scale_val   (scale_val),
    .gain_val    (gain_val),
    .mode        (mode),
    .param_valid (param_valid),
    .param_ready (param_ready),
`ifdef DRFM_CMD_READBACK_EN
    .readback    (readback),
`endif
    .status      (status)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic toggle();
    upd_tgl = ~upd_tgl;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    aclr        = 1'b1;
    upd_tgl     = 1'b1;
    cmd_word    = 32'h0;
    param_ready = 1'b0;

    // Reset with upd_tgl held high: no event may come out of the synchronizer.
    step(3);
    aclr = 1'b0;
    check("rst_mode",   mode,        4'b0000);
    check("rst_valid",  param_valid, 1'b0);
    check("rst_status", status,      4'b0000);
    check("rst_delay",  delay_val,   7'd0);
    for (int i = 0; i < 8; i++) begin
      step(1);
      check("rst_no_evt", param_valid, 1'b0);
    end
    check("rst_status2", status, 4'b0000);

    // Delay command: exact latency, then accept.
    cmd_word = 32'h0000_0085;
    toggle();
    for (int i = 0; i < 4; i++) begin
      step(1);
      check("dly_lat_low", param_valid, 1'b0);
    end
    step(1);
    check("dly_valid", param_valid, 1'b1);
    check("dly_val",   delay_val,   7'd5);
    check("dly_mode",  mode,        4'b0001);
    step(1);
    check("dly_hold",  param_valid, 1'b1);
    param_ready = 1'b1;
    step(1);
    check("dly_drop",   param_valid, 1'b0);
    check("dly_status", status,      4'b0000);
    param_ready = 1'b0;

    // Doppler + gain: doppler wins priority, multi_cmd raised.
    cmd_word = 32'h8300_8A00;
    toggle();
    step(5);
    check("multi_valid",   param_valid, 1'b1);
    check("multi_doppler", doppler_val, 7'h0A);
    check("multi_gain",    gain_val,    7'h03);
    check("multi_delay",   delay_val,   7'd5);
    check("multi_mode",    mode,        4'b1000);
    check("multi_status",  status,      4'b0010);
    param_ready = 1'b1;
    step(1);
    check("multi_drop", param_valid, 1'b0);
    param_ready = 1'b0;

    // All flags clear: nop, no handshake, values kept.
    cmd_word = 32'h0000_0000;
    toggle();
    for (int i = 0; i < 8; i++) begin
      step(1);
      check("nop_no_valid", param_valid, 1'b0);
    end
    check("nop_mode",    mode,        4'b0000);
    check("nop_status",  status,      4'b0011);
    check("nop_delay",   delay_val,   7'd5);
    check("nop_doppler", doppler_val, 7'h0A);

    // Scale command with param_ready held low: valid for exactly 8 cycles.
    cmd_word = 32'h0091_0000;
    toggle();
    step(5);
    check("to_valid", param_valid, 1'b1);
    check("to_scale", scale_val,   7'h11);
    check("to_mode",  mode,        4'b0010);
    hi_cnt = 1;
    for (int i = 0; i < 12; i++) begin
      step(1);
      if (param_valid) hi_cnt++;
    end
    check("to_hi_cycles", hi_cnt,    8);
    check("to_status",    status,    4'b1011);
    check("to_scale_kept", scale_val, 7'h11);

    // Three toggles during one handshake: one pend, overrun, pend serviced.
    cmd_word = 32'h0000_0081;
    toggle();
    step(5);
    check("ovr_valid1", param_valid, 1'b1);
    check("ovr_delay1", delay_val,   7'd1);
    check("ovr_mode1",  mode,        4'b0001);
    cmd_word = 32'h8200_0000;
    toggle();
    step(2);
    toggle();
    step(2);
    toggle();
    step(2);
    check("ovr_still_valid", param_valid, 1'b1);
    check("ovr_status",      status,      4'b1111);
    check("ovr_delay_stable", delay_val,  7'd1);
    param_ready = 1'b1;
    step(1);
    check("ovr_drop", param_valid, 1'b0);
    step(3);
    check("ovr_pend_valid", param_valid, 1'b1);
    check("ovr_pend_gain",  gain_val,    7'd2);
    check("ovr_pend_mode",  mode,        4'b0100);
    check("ovr_pend_delay", delay_val,   7'd1);
    step(1);
    check("ovr_pend_drop", param_valid, 1'b0);
    param_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      check("ovr_single_pend", param_valid, 1'b0);
    end

    // aclr mid-handshake with a pend queued: everything discarded.
    cmd_word = 32'h0000_0083;
    toggle();
    step(5);
    check("abort_valid", param_valid, 1'b1);
    check("abort_delay", delay_val,   7'd3);
    toggle();
    step(3);
    check("abort_pre_valid", param_valid, 1'b1);
    aclr = 1'b1;
    step(1);
    check("abort_valid0", param_valid, 1'b0);
    check("abort_status", status,      4'b0000);
    check("abort_mode",   mode,        4'b0000);
    check("abort_delay0", delay_val,   7'd0);
    check("abort_gain0",  gain_val,    7'd0);
    aclr = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      check("abort_no_pend", param_valid, 1'b0);
    end
    check("abort_status2", status, 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
